vga_text_writer: RTL

//  Upstream feeder for the VGA text display. Consumes a byte stream (valid/ready)
//  and writes characters into the write port of the text RAM that the VGA text

---
 rtl/vga_text_writer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/vga_text_writer.sv
// Purpose: feeds the VGA text RAM from a byte stream; keeps a cursor and handles CR/LF/BS/FF.
// Latency: an accepted byte produces its RAM write on the next cycle; runs at one byte per cycle.
// Backpressure: in_ready is low while a full-screen or single-line clear is running.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   in_data/_valid    input byte stream; in_ready is the handshake response
//   wr_en/_addr/_data text RAM write port, address = row*TextCols+col
//   cur_col, cur_row  cursor position
module vga_text_writer #(
  parameter int          TextCols  = 64,
  parameter int          TextRows  = 32,
  parameter logic [7:0]  BlankChar = 8'h20,
  parameter int          AW        = $clog2(TextCols * TextRows)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        wr_en,
  output logic [AW-1:0]               wr_addr,
  output logic [7:0]                  wr_data,
  output logic [$clog2(TextCols)-1:0] cur_col,
  output logic [$clog2(TextRows)-1:0] cur_row
);

  localparam int CW = $clog2(TextCols);
  localparam int RW = $clog2(TextRows);
  // Clear counter is one bit wider than the address so it can count one past the
  // last cell; the extra step keeps in_ready low until the final blank write is out.
  localparam int NW = AW + 1;
  localparam logic [NW-1:0] TotalCells = NW'(TextCols * TextRows);
  localparam logic [NW-1:0] LineCells  = NW'(TextCols);
  localparam logic [AW-1:0] ColsAw     = AW'(TextCols);

  localparam logic [7:0] ChCr = 8'h0D;
  localparam logic [7:0] ChLf = 8'h0A;
  localparam logic [7:0] ChBs = 8'h08;
  localparam logic [7:0] ChFf = 8'h0C;

  typedef enum logic [1:0] {
    sClrAll  = 2'b00,
    sIdle    = 2'b01,
    sClrLine = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_col,     w_col_nxt;
  logic [RW-1:0]   r_row,     w_row_nxt;
  logic [NW-1:0]   r_cnt,     w_cnt_nxt;
  logic            r_wr_en,   w_wr_en_nxt;
  logic [AW-1:0]   r_wr_addr, w_wr_addr_nxt;
  logic [7:0]      r_wr_data, w_wr_data_nxt;
  logic            r_in_ready;

  logic            w_accept;
  logic [AW-1:0]   w_line_base;
  logic [AW-1:0]   w_cur_addr;
  logic [RW-1:0]   w_row_inc;
  logic            w_col_last;

  assign w_accept    = in_valid & r_in_ready;
  assign w_line_base = AW'(r_row) * ColsAw;
  assign w_cur_addr  = w_line_base + AW'(r_col);
  assign w_row_inc   = (r_row == RW'(TextRows - 1)) ? '0 : r_row + 1'b1;
  assign w_col_last  = (r_col == CW'(TextCols - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= sClrAll;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      sClrAll:  if (r_cnt == TotalCells) w_state_nxt = sIdle;
      sClrLine: if (r_cnt == LineCells)  w_state_nxt = sIdle;
      sIdle: begin
        if (w_accept) begin
          case (in_data)
            ChCr, ChBs: w_state_nxt = sIdle;
            ChLf:       w_state_nxt = sClrLine;
            ChFf:       w_state_nxt = sClrAll;
            default:    w_state_nxt = w_col_last ? sClrLine : sIdle;
          endcase
        end
      end
      default:  w_state_nxt = sClrAll;
    endcase
  end

  // Next values of the registered outputs and cursor/counter
  always_comb begin
    w_col_nxt     = r_col;
    w_row_nxt     = r_row;
    w_cnt_nxt     = r_cnt;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    case (r_state)
      sClrAll: begin
        w_col_nxt = '0;
        w_row_nxt = '0;
        if (r_cnt != TotalCells) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_cnt[AW-1:0];
          w_wr_data_nxt = BlankChar;
          w_cnt_nxt     = r_cnt + 1'b1;
        end else begin
          w_cnt_nxt = '0;
        end
      end
      sClrLine: begin
        if (r_cnt != LineCells) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = w_line_base + AW'(r_cnt);
          w_wr_data_nxt = BlankChar;
          w_cnt_nxt     = r_cnt + 1'b1;
        end else begin
          w_cnt_nxt = '0;
        end
      end
      sIdle: begin
        if (w_accept) begin
          w_cnt_nxt = '0;
          case (in_data)
            ChCr: w_col_nxt = '0;
            ChLf: begin
              w_col_nxt = '0;
              w_row_nxt = w_row_inc;
            end
            ChBs: begin
              if (r_col != '0) begin
                w_col_nxt     = r_col - 1'b1;
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = w_cur_addr - 1'b1;
                w_wr_data_nxt = BlankChar;
              end
            end
            ChFf: begin
              w_col_nxt = '0;
              w_row_nxt = '0;
            end
            default: begin
              w_wr_en_nxt   = 1'b1;
              w_wr_addr_nxt = w_cur_addr;
              w_wr_data_nxt = in_data;
              if (w_col_last) begin
                w_col_nxt = '0;
                w_row_nxt = w_row_inc;
              end else begin
                w_col_nxt = r_col + 1'b1;
              end
            end
          endcase
        end
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col      <= '0;
      r_row      <= '0;
      r_cnt      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      r_cnt      <= w_cnt_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_in_ready <= (w_state_nxt == sIdle);
    end
  end

  assign in_ready = r_in_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign cur_col  = r_col;
  assign cur_row  = r_row;

endmodule
